// File: rtl/wash_cycle_controller.sv
// Washing-machine sequencer: runs a stored preset through FILL, WASH, RINSE and SPIN.
// Phase lengths are counted in time units of TICK_DIV clock cycles.
module wash_cycle_controller #(
  parameter int TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       pause,
  input  logic       abort,
  output logic [1:0] preset_sel,
  input  logic [4:0] wash_in,
  input  logic [4:0] rinse_in,
  input  logic [4:0] spin_in,
  input  logic [4:0] cloth_in,
  output logic [2:0] phase,
  output logic [4:0] remaining,
  output logic       valve_open,
  output logic       motor_on,
  output logic       motor_fast,
  output logic       drain_open,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FILL  = 3'd2,
    WASH  = 3'd3,
    RINSE = 3'd4,
    SPIN  = 3'd5,
    DONE  = 3'd6,
    BAD   = 3'd7
  } phase_t;

  localparam logic [7:0] PRE_MAX = 8'(TICK_DIV - 1);

  phase_t     state, next_state;
  logic [7:0] prescaler;
  logic [4:0] rem_q;
  logic [4:0] wash_q, rinse_q, spin_q;
  logic       timed, kill, advance;
  logic [4:0] next_dur;

  assign timed   = (state == FILL) || (state == WASH) || (state == RINSE) || (state == SPIN);
  assign kill    = (abort && (state != IDLE)) || (state == BAD);
  assign advance = timed && !pause && (rem_q == 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = LOAD;
      LOAD:    next_state = FILL;
      FILL:    if (advance) next_state = WASH;
      WASH:    if (advance) next_state = RINSE;
      RINSE:   if (advance) next_state = SPIN;
      SPIN:    if (advance) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (kill) next_state = IDLE;
  end

  // Duration to load when the current timed phase hands over to the next one.
  always_comb begin
    next_dur = 5'd0;
    case (state)
      FILL:    next_dur = wash_q;
      WASH:    next_dur = rinse_q;
      RINSE:   next_dur = spin_q;
      default: next_dur = 5'd0;
    endcase
  end

  // FILL's duration goes straight into remaining at LOAD, so it needs no separate copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      preset_sel <= 2'd0;
      rem_q      <= 5'd0;
      prescaler  <= 8'd0;
      wash_q     <= 5'd0;
      rinse_q    <= 5'd0;
      spin_q     <= 5'd0;
    end else if (kill) begin
      rem_q     <= 5'd0;
      prescaler <= 8'd0;
    end else if (state == IDLE) begin
      if (start) preset_sel <= mode;
    end else if (state == LOAD) begin
      wash_q    <= wash_in;
      rinse_q   <= rinse_in;
      spin_q    <= spin_in;
      rem_q     <= cloth_in;
      prescaler <= 8'd0;
    end else if (timed && !pause) begin
      if (rem_q == 5'd0) begin
        rem_q     <= next_dur;
        prescaler <= 8'd0;
      end else if (prescaler == PRE_MAX) begin
        prescaler <= 8'd0;
        rem_q     <= rem_q - 5'd1;
      end else begin
        prescaler <= prescaler + 8'd1;
      end
    end
  end

  always_comb begin
    phase      = state;
    remaining  = timed ? rem_q : 5'd0;
    valve_open = (state == FILL) || (state == RINSE);
    motor_on   = (state == WASH) || (state == RINSE);
    motor_fast = (state == SPIN);
    drain_open = (state == SPIN);
    busy       = (state != IDLE);
    done       = (state == DONE);
  end

endmodule

// File: tb/tb_wash_cycle_controller.sv
// Directed bench for wash_cycle_controller at TICK_DIV=2 with a small preset store model.
// Phase lengths, done timing and actuator decode are checked against hand-computed tables.
module tb_wash_cycle_controller;

  logic       clk, rst_n, start, pause, abort;
  logic [1:0] mode, preset_sel;
  logic [4:0] wash_in, rinse_in, spin_in, cloth_in, remaining;
  logic [2:0] phase;
  logic       valve_open, motor_on, motor_fast, drain_open, busy, done;
  logic       override;

  logic [4:0] p_cloth [4];
  logic [4:0] p_wash  [4];
  logic [4:0] p_rinse [4];
  logic [4:0] p_spin  [4];

  int total = 0;
  int bad   = 0;
  int lens [8];
  int done_at, done_cnt;

  typedef struct {
    logic [1:0] m;
    int pause_at;
    int pause_len;
    int over_at;
    int exp_fill;
    int exp_wash;
    int exp_rinse;
    int exp_spin;
    int exp_done;
  } vec_t;

  vec_t vecs [6];

  wash_cycle_controller #(.TICK_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .pause(pause), .abort(abort),
    .preset_sel(preset_sel), .wash_in(wash_in), .rinse_in(rinse_in), .spin_in(spin_in),
    .cloth_in(cloth_in), .phase(phase), .remaining(remaining), .valve_open(valve_open),
    .motor_on(motor_on), .motor_fast(motor_fast), .drain_open(drain_open), .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Preset store; override forces every field to 31 to prove fields are latched.
  always_comb begin
    cloth_in = override ? 5'd31 : p_cloth[preset_sel];
    wash_in  = override ? 5'd31 : p_wash[preset_sel];
    rinse_in = override ? 5'd31 : p_rinse[preset_sel];
    spin_in  = override ? 5'd31 : p_spin[preset_sel];
  end

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic start_and_advance(input logic [1:0] m, input int k);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (k - 1) @(negedge clk);
  endtask

  task automatic apply_stimulus(input vec_t v);
    int n, prev, ph, snap_ph, snap_rem, exp_rem;
    for (int i = 0; i < 8; i++) lens[i] = 0;
    done_at  = 0;
    done_cnt = 0;
    prev     = -1;
    snap_ph  = 0;
    snap_rem = 0;
    @(negedge clk);
    mode  = v.m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_output("preset_sel_after_start", int'(preset_sel), int'(v.m));
    n = 1;
    for (int c = 0; c < 400; c++) begin
      ph = int'(phase);
      if (ph == 0) break;
      lens[ph]++;
      check_output("busy", int'(busy), 1);
      check_output("valve_open", int'(valve_open), int'(ph == 2 || ph == 4));
      check_output("motor_on", int'(motor_on), int'(ph == 3 || ph == 4));
      check_output("motor_fast", int'(motor_fast), int'(ph == 5));
      check_output("drain_open", int'(drain_open), int'(ph == 5));
      check_output("done_decode", int'(done), int'(ph == 6));
      if (ph == 1 || ph == 6) check_output("remaining_zero", int'(remaining), 0);
      if (ph != prev && ph >= 2 && ph <= 5) begin
        case (ph)
          2:       exp_rem = int'(p_cloth[v.m]);
          3:       exp_rem = int'(p_wash[v.m]);
          4:       exp_rem = int'(p_rinse[v.m]);
          default: exp_rem = int'(p_spin[v.m]);
        endcase
        check_output("remaining_entry", int'(remaining), exp_rem);
      end
      if (v.pause_at > 0 && n > v.pause_at && n <= v.pause_at + v.pause_len) begin
        check_output("pause_phase_frozen", ph, snap_ph);
        check_output("pause_remaining_frozen", int'(remaining), snap_rem);
      end
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = n;
      end
      prev = ph;
      if (n == v.pause_at) begin
        pause    = 1'b1;
        snap_ph  = ph;
        snap_rem = int'(remaining);
      end
      if (n == v.pause_at + v.pause_len) pause = 1'b0;
      if (n == v.over_at) override = 1'b1;
      @(negedge clk);
      n++;
    end
    pause    = 1'b0;
    override = 1'b0;
    check_output("returned_idle", int'(phase), 0);
    check_output("fill_cycles", lens[2], v.exp_fill);
    check_output("wash_cycles", lens[3], v.exp_wash);
    check_output("rinse_cycles", lens[4], v.exp_rinse);
    check_output("spin_cycles", lens[5], v.exp_spin);
    check_output("done_cycle", done_at, v.exp_done);
    check_output("done_width", done_cnt, 1);
  endtask

  initial begin
    p_cloth = '{5'd0, 5'd3, 5'd1, 5'd31};
    p_wash  = '{5'd0, 5'd0, 5'd2, 5'd1};
    p_rinse = '{5'd0, 5'd2, 5'd1, 5'd0};
    p_spin  = '{5'd0, 5'd4, 5'd1, 5'd2};
    // Each timed phase lasts N*2+1 cycles; done is seen in cycle 1+sum(lengths)+1.
    vecs[0] = '{2'd2, -1, 0, -1,  3, 5, 3, 3, 16};
    vecs[1] = '{2'd0, -1, 0, -1,  1, 1, 1, 1,  6};
    vecs[2] = '{2'd1, -1, 0, -1,  7, 1, 5, 9, 24};
    vecs[3] = '{2'd3, -1, 0, -1, 63, 3, 1, 5, 74};
    vecs[4] = '{2'd2,  6, 4, -1,  3, 9, 3, 3, 20};
    vecs[5] = '{2'd2, -1, 0,  6,  3, 5, 3, 3, 16};

    rst_n    = 1'b0;
    start    = 1'b0;
    mode     = 2'd0;
    pause    = 1'b0;
    abort    = 1'b0;
    override = 1'b0;
    #12;
    check_output("reset_phase", int'(phase), 0);
    check_output("reset_preset_sel", int'(preset_sel), 0);
    check_output("reset_remaining", int'(remaining), 0);
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) apply_stimulus(vecs[i]);

    // Abort in the first RINSE cycle, then a normal run.
    start_and_advance(2'd2, 10);
    check_output("abort_pre_phase", int'(phase), 4);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_output("abort_phase", int'(phase), 0);
    check_output("abort_valve", int'(valve_open), 0);
    check_output("abort_motor", int'(motor_on), 0);
    check_output("abort_done", int'(done), 0);
    check_output("abort_remaining", int'(remaining), 0);
    apply_stimulus(vecs[0]);

    // Reset pulse in SPIN clears outputs with no clock edge in between.
    start_and_advance(2'd2, 14);
    check_output("spin_pre_phase", int'(phase), 5);
    check_output("spin_pre_motor_fast", int'(motor_fast), 1);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_phase", int'(phase), 0);
    check_output("async_motor_fast", int'(motor_fast), 0);
    check_output("async_drain", int'(drain_open), 0);
    check_output("async_busy", int'(busy), 0);
    check_output("async_done", int'(done), 0);
    check_output("async_preset_sel", int'(preset_sel), 0);
    @(negedge clk);
    rst_n = 1'b1;
    mode  = 2'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_output("first_start_phase", int'(phase), 1);
    check_output("first_start_sel", int'(preset_sel), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_output("abort_load_phase", int'(phase), 0);

    // Start held through DONE must not relaunch a cycle.
    start_and_advance(2'd0, 6);
    check_output("done_phase", int'(phase), 6);
    check_output("done_pulse", int'(done), 1);
    mode  = 2'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_output("after_done_phase", int'(phase), 0);
    check_output("after_done_busy", int'(busy), 0);
    @(negedge clk);
    check_output("still_idle", int'(phase), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wash_cycle_controller.md
WASH_CYCLE_CONTROLLER -- requirements
Module: wash_cycle_controller

Interface
REQ-001 The module SHALL have parameter TICK_DIV, default 4, giving clock cycles per time unit (legal range 2..255).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 start  input  1  request to run a cycle with preset `mode`; sampled only in IDLE.
REQ-005 mode  input  2  preset number to run.
REQ-006 pause  input  1  while high, SHALL freeze the timer and hold the current phase.
REQ-007 abort  input  1  cancels the running cycle.
REQ-008 preset_sel  output  2  preset number driven to the preset store read mux.
REQ-009 wash_in, rinse_in, spin_in, cloth_in  input  5 each  preset fields returned by the store for preset_sel; combinational from preset_sel.
REQ-010 phase  output  3  current state encoding.
REQ-011 remaining  output  5  time units left in the current phase.
REQ-012 valve_open, motor_on, motor_fast, drain_open  output  1 each  actuator drives.
REQ-013 busy  output  1  high whenever phase is not IDLE.
REQ-014 done  output  1  one-cycle completion pulse.

Function
REQ-015 The state machine SHALL use these phase encodings: IDLE=0, LOAD=1, FILL=2, WASH=3, RINSE=4, SPIN=5, DONE=6; 7 SHALL be unreachable and, if entered, SHALL recover to IDLE next cycle.
REQ-016 When start=1 in IDLE, the next state SHALL be LOAD, and preset_sel SHALL register mode on that edge; otherwise preset_sel SHALL hold.
REQ-017 LOAD SHALL last exactly one cycle, latching all four fields into internal registers, then go to FILL.
REQ-018 Phase order SHALL be FILL (duration cloth), WASH (wash), RINSE (rinse), SPIN (spin), then DONE.
REQ-019 On entering a timed phase, remaining SHALL load the phase's latched duration N and the prescaler SHALL clear to 0.
REQ-020 Each unpaused cycle in a timed phase: if remaining==0, advance to the next phase; else increment the prescaler, and at TICK_DIV-1 clear it and decrement remaining.
REQ-021 A timed phase SHALL therefore last N*TICK_DIV+1 unpaused cycles; N=0 SHALL last exactly 1 cycle (no skipping).
REQ-022 pause SHALL freeze the prescaler, remaining and phase; actuator outputs SHALL stay at the values for the current phase; pause SHALL have no effect in IDLE, LOAD or DONE.
REQ-023 DONE SHALL last one cycle with done=1, then return to IDLE; start in DONE SHALL be ignored.
REQ-024 abort=1 in any non-IDLE state SHALL force IDLE next cycle with done=0, and SHALL take priority over pause and start.
REQ-025 The latched fields SHALL hold for the whole cycle; input field changes after LOAD SHALL have no effect.
REQ-026 Actuator outputs SHALL be decoded from phase:
- valve_open: FILL or RINSE.
- motor_on: WASH or RINSE.
- motor_fast and drain_open: SPIN.
- All others: 0.
REQ-027 remaining SHALL read 0 in IDLE, LOAD and DONE.

Reset
REQ-028 While rst_n=0, the block SHALL immediately set phase=IDLE, preset_sel=0, remaining=0, prescaler=0, latched fields=0, and every actuator, busy and done to 0.
REQ-029 After rst_n deasserts, the first start SHALL be accepted on the first rising edge.
REQ-030 Reset asserted mid-cycle SHALL clear all state asynchronously, with no done pulse.

Verification (TICK_DIV=2)
REQ-031 Preset 2 = cloth 1, wash 2, rinse 1, spin 1; pulse start with mode=2 -> preset_sel=2, then:
- LOAD 1 cycle; FILL 3; WASH 5; RINSE 3; SPIN 3.
- done high exactly 1 cycle, 16 cycles after the start edge.
REQ-032 All fields 0 -> each timed phase lasts 1 cycle; done occurs 6 cycles after the start edge.
REQ-033 pause held 4 cycles mid-WASH -> remaining and phase frozen, motor_on stays 1, total length grows by exactly 4 cycles.
REQ-034 abort during RINSE -> IDLE next cycle, all actuators 0, no done; a following start runs normally.
REQ-035 rst_n pulsed low during SPIN -> outputs 0 immediately, without a clock edge; start held high during DONE -> ignored, busy=0 after DONE.
REQ-036 Fields changed to 31 during WASH -> remaining timing unchanged from the latched values.
